// File: rtl/soc_evt_fifo_mc.sv
// Multi-source event FIFO: round-robin arbiter feeding one shared FWFT FIFO tagged with source index.
// Latency: push -> pop_valid_o one cycle (no empty bypass); pop_data_o is combinational from the head slot.
// Backpressure: stall mode grants at most one source per cycle and holds the rest; drop mode is always ready and counts losses.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   evt_valid_i/ready_o     per-source valid/ready handshake
//   evt_data_i              per-source event ID (packed NB_SRC x EVNT_WIDTH)
//   pop_req_i               consume head entry (ignored while empty)
//   pop_valid_o, event_o    head valid / event line (both == level_o != 0)
//   pop_data_o              {source index, event ID} at head
//   level_o                 registered occupancy
//   afull_thresh_i          almost-full threshold; almost_full_o = level_o >= threshold
//   drop_cnt_o, drop_clr_i  saturating drop counter and its clear (clear beats same-cycle drops)
module soc_evt_fifo_mc #(
  parameter int NB_SRC       = 2,
  parameter int EVNT_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int DROP_ON_FULL = 0,
  parameter int DROP_CNT_W   = 16,
  localparam int SRC_W       = (NB_SRC > 1) ? $clog2(NB_SRC) : 1,
  localparam int LVL_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NB_SRC-1:0]                    evt_valid_i,
  output logic [NB_SRC-1:0]                    evt_ready_o,
  input  logic [NB_SRC-1:0][EVNT_WIDTH-1:0]    evt_data_i,
  input  logic                                 pop_req_i,
  output logic                                 pop_valid_o,
  output logic [SRC_W+EVNT_WIDTH-1:0]          pop_data_o,
  output logic                                 event_o,
  output logic [LVL_W-1:0]                     level_o,
  input  logic [LVL_W-1:0]                     afull_thresh_i,
  output logic                                 almost_full_o,
  output logic [DROP_CNT_W-1:0]                drop_cnt_o,
  input  logic                                 drop_clr_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = SRC_W + EVNT_WIDTH;
  // Width able to hold the number of valid sources in one cycle.
  localparam int NDW   = $clog2(NB_SRC + 1);
  // One extra bit above the wider operand so saturation is detected by the carry-out.
  localparam int SUM_W = ((DROP_CNT_W > NDW) ? DROP_CNT_W : NDW) + 1;

  logic [ENT_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic [LVL_W-1:0]      level_q;
  logic [SRC_W-1:0]      rr_ptr;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  logic                  full;
  logic                  empty;
  logic                  can_push;
  logic                  push;
  logic                  pop;

  logic                  gnt_vld;
  logic [SRC_W-1:0]      gnt_idx;
  logic [NB_SRC-1:0]     gnt_oh;
  logic [SRC_W-1:0]      rr_nxt;
  logic [SRC_W-1:0]      cand;
  int                    arb_idx;

  logic [NDW-1:0]        vld_cnt;
  logic [NDW-1:0]        n_drop;

  // Pointer status: same slot index with differing wrap bit means full.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                    (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  // A same-cycle pop frees the slot being written, so a full FIFO may still accept.
  assign can_push = !full || (pop_req_i && !empty);
  assign pop      = pop_req_i && !empty;
  assign push     = gnt_vld && can_push;

  // Round-robin search starting at rr_ptr; grant does not look at can_push.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    arb_idx = 0;
    cand    = '0;
    for (int k = 0; k < NB_SRC; k++) begin
      arb_idx = (int'(rr_ptr) + k) % NB_SRC;
      cand    = SRC_W'(arb_idx);
      if (!gnt_vld && evt_valid_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

  assign rr_nxt = (gnt_idx == SRC_W'(NB_SRC - 1)) ? '0 : gnt_idx + 1'b1;

  // Valid sources this cycle; all but the pushed one are lost in drop mode.
  always_comb begin
    vld_cnt = '0;
    for (int i = 0; i < NB_SRC; i++) vld_cnt = vld_cnt + NDW'(evt_valid_i[i]);
  end
  assign n_drop = vld_cnt - NDW'(push);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Storage is cleared too so pop_data_o is defined while empty.
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      rr_ptr  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[PTR_W-1:0]] <= {gnt_idx, evt_data_i[gnt_idx]};
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= rr_nxt;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  generate
    if (DROP_ON_FULL != 0) begin : g_drop
      logic [SUM_W-1:0] drop_sum;

      assign drop_sum    = SUM_W'(drop_cnt_q) + SUM_W'(n_drop);
      assign evt_ready_o = '1;

      always_ff @(posedge clk_i) begin
        if (rst_i || drop_clr_i) begin
          drop_cnt_q <= '0;
        end else if (|drop_sum[SUM_W-1:DROP_CNT_W]) begin
          drop_cnt_q <= '1;
        end else begin
          drop_cnt_q <= drop_sum[DROP_CNT_W-1:0];
        end
      end
    end else begin : g_stall
      logic unused_drop;

      assign evt_ready_o = gnt_oh & {NB_SRC{can_push}};
      assign drop_cnt_q  = '0;
      assign unused_drop = drop_clr_i ^ (|n_drop);
    end
  endgenerate

  assign pop_valid_o   = (level_q != '0);
  assign event_o       = (level_q != '0);
  assign pop_data_o    = mem[rd_ptr[PTR_W-1:0]];
  assign level_o       = level_q;
  assign almost_full_o = (level_q >= afull_thresh_i);
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_soc_evt_fifo_mc.sv
// Directed bench: one stall-mode instance (defaults) and one drop-mode instance with a 4-bit drop counter.
// Inputs change 1 time unit after the rising edge; outputs are checked in the same low-activity window.
// Ends with a single summary line.
module tb_soc_evt_fifo_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Stall-mode instance signals
  logic [1:0]      s_valid, s_ready;
  logic [1:0][7:0] s_data;
  logic            s_pop, s_pvld, s_evt, s_af, s_clr;
  logic [8:0]      s_pdat;
  logic [3:0]      s_lvl, s_thr;
  logic [15:0]     s_dcnt;

  // Drop-mode instance signals
  logic [1:0]      d_valid, d_ready;
  logic [1:0][7:0] d_data;
  logic            d_pop, d_pvld, d_evt, d_af, d_clr;
  logic [8:0]      d_pdat;
  logic [3:0]      d_lvl, d_thr;
  logic [3:0]      d_dcnt;

  int total = 0;
  int bad   = 0;

  soc_evt_fifo_mc u_stl (
    .clk_i(clk), .rst_i(rst),
    .evt_valid_i(s_valid), .evt_ready_o(s_ready), .evt_data_i(s_data),
    .pop_req_i(s_pop), .pop_valid_o(s_pvld), .pop_data_o(s_pdat), .event_o(s_evt),
    .level_o(s_lvl), .afull_thresh_i(s_thr), .almost_full_o(s_af),
    .drop_cnt_o(s_dcnt), .drop_clr_i(s_clr)
  );

  soc_evt_fifo_mc #(.DROP_ON_FULL(1), .DROP_CNT_W(4)) u_drp (
    .clk_i(clk), .rst_i(rst),
    .evt_valid_i(d_valid), .evt_ready_o(d_ready), .evt_data_i(d_data),
    .pop_req_i(d_pop), .pop_valid_o(d_pvld), .pop_data_o(d_pdat), .event_o(d_evt),
    .level_o(d_lvl), .afull_thresh_i(d_thr), .almost_full_o(d_af),
    .drop_cnt_o(d_dcnt), .drop_clr_i(d_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] fair_exp [4];
  int n0, n1;

  initial begin
    fair_exp[0] = 9'h010; fair_exp[1] = 9'h120;
    fair_exp[2] = 9'h011; fair_exp[3] = 9'h121;

    rst = 1'b1;
    s_valid = '0; s_data = '0; s_pop = 1'b0; s_thr = 4'd0; s_clr = 1'b0;
    d_valid = '0; d_data = '0; d_pop = 1'b0; d_thr = 4'd6; d_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_pvld", 32'(s_pvld), 0);
    chk("rst_evt",  32'(s_evt),  0);
    chk("rst_lvl",  32'(s_lvl),  0);
    chk("rst_pdat", 32'(s_pdat), 0);
    chk("rst_af_thr0", 32'(s_af), 1);
    chk("rst_dcnt", 32'(s_dcnt), 0);
    s_thr = 4'd6;
    #1;
    chk("rst_af_thr6", 32'(s_af), 0);

    // Single push from src1
    s_valid = 2'b10; s_data[1] = 8'h2A;
    #1;
    chk("single_rdy", 32'(s_ready), 32'h2);
    step();
    s_valid = '0;
    chk("single_pvld", 32'(s_pvld), 1);
    chk("single_evt",  32'(s_evt),  1);
    chk("single_pdat", 32'(s_pdat), 32'h12A);
    chk("single_lvl",  32'(s_lvl),  1);
    s_pop = 1'b1;
    step();
    s_pop = 1'b0;
    chk("single_pop_lvl", 32'(s_lvl), 0);
    chk("single_pop_evt", 32'(s_evt), 0);

    // Fairness: both held valid, data advances only on handshake
    n0 = 0; n1 = 0;
    for (int c = 0; c < 4; c++) begin
      s_valid = 2'b11;
      s_data[0] = 8'h10 + 8'(n0);
      s_data[1] = 8'h20 + 8'(n1);
      #1;
      chk($sformatf("fair_rdy%0d", c), 32'(s_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
      if (s_ready[0]) n0++;
      if (s_ready[1]) n1++;
      step();
    end
    s_valid = '0;
    chk("fair_lvl", 32'(s_lvl), 4);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("fair_dat%0d", c), 32'(s_pdat), 32'(fair_exp[c]));
      s_pop = 1'b1;
      step();
      s_pop = 1'b0;
    end
    chk("fair_drain_lvl", 32'(s_lvl), 0);

    // Full + backpressure, pointers wrap (they start at 5 here)
    for (int i = 0; i < 8; i++) begin
      s_valid = 2'b01; s_data[0] = 8'h30 + 8'(i);
      step();
    end
    s_valid = 2'b01; s_data[0] = 8'h38;
    #1;
    chk("full_lvl", 32'(s_lvl), 8);
    chk("full_rdy", 32'(s_ready), 0);
    chk("full_af",  32'(s_af), 1);
    s_pop = 1'b1;
    #1;
    chk("full_pop_rdy",  32'(s_ready), 32'h1);
    chk("full_pop_head", 32'(s_pdat), 32'h030);
    step();
    s_pop = 1'b0; s_valid = '0;
    chk("full_pp_lvl", 32'(s_lvl), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wrap_dat%0d", i), 32'(s_pdat), 32'h031 + 32'(i));
      s_pop = 1'b1;
      step();
      s_pop = 1'b0;
    end
    chk("wrap_lvl", 32'(s_lvl), 0);

    // Almost-full at threshold 6
    for (int i = 0; i < 5; i++) begin
      s_valid = 2'b10; s_data[1] = 8'h40 + 8'(i);
      step();
    end
    s_valid = '0;
    chk("af5_lvl", 32'(s_lvl), 5);
    chk("af5",     32'(s_af), 0);
    s_valid = 2'b10; s_data[1] = 8'h45;
    step();
    s_valid = '0;
    chk("af6", 32'(s_af), 1);
    s_pop = 1'b1;
    step();
    s_pop = 1'b0;
    chk("af_pop", 32'(s_af), 0);
    chk("af_pop_lvl", 32'(s_lvl), 5);

    // Reset mid-operation
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_lvl",  32'(s_lvl), 0);
    chk("mrst_evt",  32'(s_evt), 0);
    chk("mrst_pvld", 32'(s_pvld), 0);
    s_pop = 1'b1;
    step();
    s_pop = 1'b0;
    chk("empty_pop_lvl", 32'(s_lvl), 0);

    // Drop mode: fill with single source, no drops
    #1;
    chk("drp_rdy_idle", 32'(d_ready), 32'h3);
    for (int i = 0; i < 8; i++) begin
      d_valid = 2'b01; d_data[0] = 8'h50 + 8'(i);
      step();
    end
    chk("drp_fill_lvl",  32'(d_lvl), 8);
    chk("drp_fill_dcnt", 32'(d_dcnt), 0);

    // Full, both valid for 3 cycles: 2 drops each
    d_valid = 2'b11; d_data[0] = 8'hE0; d_data[1] = 8'hF0;
    step(); step(); step();
    chk("drp_dcnt6", 32'(d_dcnt), 6);
    chk("drp_lvl_hold", 32'(d_lvl), 8);
    chk("drp_head_hold", 32'(d_pdat), 32'h050);

    // Clear wins over same-cycle drops
    d_clr = 1'b1;
    step();
    d_clr = 1'b0;
    chk("drp_clr", 32'(d_dcnt), 0);

    // Saturation: 10 cycles x 2 drops = 20 -> 15, then held
    for (int i = 0; i < 10; i++) step();
    chk("drp_sat", 32'(d_dcnt), 15);
    step();
    chk("drp_sat_hold", 32'(d_dcnt), 15);

    // Pop while full with both valid: one pushed (src1, rr=1), one dropped
    d_valid = '0; d_clr = 1'b1;
    step();
    d_clr = 1'b0;
    d_valid = 2'b11; d_pop = 1'b1;
    step();
    d_valid = '0; d_pop = 1'b0;
    chk("drp_pp_dcnt", 32'(d_dcnt), 1);
    chk("drp_pp_lvl",  32'(d_lvl), 8);
    chk("drp_pp_head", 32'(d_pdat), 32'h051);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
